// File: rtl/bayer_to_rgb.sv
// Bayer (G1 R / B G2) to RGB demosaicer: each 2x2 quad yields one RGB pixel.
// The even row is buffered and the odd row combines with it through a 2-stage pipeline.
module bayer_to_rgb #(
    parameter int LINE_WIDTH  = 1600,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [11:0]            iDATA,
    input  logic                   iDVAL,
    input  logic                   iFVAL,
    output logic [11:0]            oR,
    output logic [11:0]            oG,
    output logic [11:0]            oB,
    output logic                   oDVAL,
    output logic [10:0]            oX_CONT,
    output logic [10:0]            oY_CONT,
    output logic [FRAME_CNT_W-1:0] oFRAME_CNT
);

    localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    logic [10:0]            col_reg;
    logic [10:0]            row_reg;
    logic                   dval_d_reg;
    logic                   fval_d_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;

    logic [11:0]            line_mem [0:LINE_WIDTH-1];
    logic [11:0]            rd_data_reg;
    logic [11:0]            b_hold_reg;

    logic                   s1_valid_reg;
    logic [11:0]            s1_g_reg;
    logic [11:0]            s1_b_reg;
    logic [10:0]            s1_x_reg;
    logic [10:0]            s1_y_reg;

    logic                   pix_valid;
    logic                   in_range;
    logic                   wr_en;
    logic                   rd_en;
    logic [AW-1:0]          addr;
    logic [12:0]            g_sum;

    assign pix_valid = iFVAL & iDVAL;
    // 12-bit compare so a LINE_WIDTH of 2048 does not wrap to zero
    assign in_range  = ({1'b0, col_reg} < 12'(LINE_WIDTH));
    assign wr_en     = pix_valid & in_range & ~row_reg[0];
    assign rd_en     = pix_valid & in_range &  row_reg[0];
    assign addr      = col_reg[AW-1:0];
    assign g_sum     = {1'b0, rd_data_reg} + {1'b0, iDATA};

    // Line buffer: no reset so it maps onto block RAM; read is registered.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            line_mem[addr] <= iDATA;
        end
        if (rd_en) begin
            rd_data_reg <= line_mem[addr];
        end
    end

    // Column/row position and frame counting.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            col_reg       <= '0;
            row_reg       <= '0;
            dval_d_reg    <= 1'b0;
            fval_d_reg    <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            fval_d_reg <= iFVAL;
            if (fval_d_reg && !iFVAL) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            if (!iFVAL) begin
                col_reg    <= '0;
                row_reg    <= '0;
                dval_d_reg <= 1'b0;
            end else if (iDVAL) begin
                dval_d_reg <= 1'b1;
                if (col_reg != 11'h7FF) begin
                    col_reg <= col_reg + 11'd1;
                end
            end else begin
                dval_d_reg <= 1'b0;
                col_reg    <= '0;
                if (dval_d_reg && row_reg != 11'h7FF) begin
                    row_reg <= row_reg + 11'd1;
                end
            end
        end
    end

    // Stage 1 on the odd-col G2: rd_data_reg still holds G1 read one cycle earlier.
    // Stage 2: rd_data_reg now holds R for this column.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            b_hold_reg   <= '0;
            s1_valid_reg <= 1'b0;
            s1_g_reg     <= '0;
            s1_b_reg     <= '0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            oR           <= '0;
            oG           <= '0;
            oB           <= '0;
            oDVAL        <= 1'b0;
            oX_CONT      <= '0;
            oY_CONT      <= '0;
        end else begin
            if (rd_en && !col_reg[0]) begin
                b_hold_reg <= iDATA;
            end
            s1_valid_reg <= rd_en & col_reg[0];
            if (rd_en && col_reg[0]) begin
                s1_g_reg <= g_sum[12:1];
                s1_b_reg <= b_hold_reg;
                s1_x_reg <= col_reg >> 1;
                s1_y_reg <= row_reg >> 1;
            end
            oDVAL <= s1_valid_reg;
            if (s1_valid_reg) begin
                oR      <= rd_data_reg;
                oG      <= s1_g_reg;
                oB      <= s1_b_reg;
                oX_CONT <= s1_x_reg;
                oY_CONT <= s1_y_reg;
            end
        end
    end

    assign oFRAME_CNT = frame_cnt_reg;

endmodule

// File: tb/tb_bayer_to_rgb.sv
// Scoreboard bench for bayer_to_rgb (LINE_WIDTH=8, 4-bit frame counter so the wrap is reachable).
// Stimulus pushes expected RGB pixels with their due cycle; a monitor pops and compares.
module tb_bayer_to_rgb;

    localparam int LW  = 8;
    localparam int FCW = 4;

    logic           CLK = 1'b0;
    logic           RESET_N = 1'b0;
    logic [11:0]    iDATA = '0;
    logic           iDVAL = 1'b0;
    logic           iFVAL = 1'b0;
    logic [11:0]    oR, oG, oB;
    logic           oDVAL;
    logic [10:0]    oX_CONT, oY_CONT;
    logic [FCW-1:0] oFRAME_CNT;

    bayer_to_rgb #(.LINE_WIDTH(LW), .FRAME_CNT_W(FCW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .iDATA(iDATA), .iDVAL(iDVAL), .iFVAL(iFVAL),
        .oR(oR), .oG(oG), .oB(oB), .oDVAL(oDVAL),
        .oX_CONT(oX_CONT), .oY_CONT(oY_CONT), .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] r, g, b;
        logic [10:0] x, y;
        int          at;
    } exp_t;

    exp_t           q[$];
    int             checks = 0;
    int             failures = 0;
    int             n_out = 0;
    logic [11:0]    line_px [0:15];
    logic [11:0]    ev [0:LW-1];
    int             brow = 0;
    logic [FCW-1:0] exp_frames = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fill(input logic [11:0] even_v, input logic [11:0] odd_v);
        for (int c = 0; c < 16; c++) line_px[c] = (c % 2 == 0) ? even_v : odd_v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            iDVAL = 1'b0;
        end
    endtask

    // Drives one line; odd rows push the expected RGB pixel for each odd column < LW.
    task automatic send_line(input int n, input bit drop_fval);
        exp_t        e;
        logic [12:0] s;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            iFVAL = 1'b1;
            iDVAL = 1'b1;
            iDATA = line_px[c];
            if (brow % 2 == 0) begin
                if (c < LW) ev[c] = line_px[c];
            end else if (c % 2 == 1 && c < LW) begin
                s    = {1'b0, ev[c-1]} + {1'b0, line_px[c]};
                e.r  = ev[c];
                e.g  = s[12:1];
                e.b  = line_px[c-1];
                e.x  = 11'((c - 1) / 2);
                e.y  = 11'(brow / 2);
                e.at = cyc + 2;
                q.push_back(e);
            end
        end
        @(negedge CLK);
        iDVAL = 1'b0;
        if (drop_fval) begin
            iFVAL = 1'b0;
            exp_frames++;
            brow = 0;
        end else begin
            brow++;
        end
    endtask

    task automatic frame_end();
        @(negedge CLK);
        iFVAL = 1'b0;
        iDVAL = 1'b0;
        exp_frames++;
        brow = 0;
        @(negedge CLK);
        @(negedge CLK);
        check("frame_cnt", 64'(oFRAME_CNT), 64'(exp_frames));
    endtask

    // Monitor: pops on every oDVAL, otherwise checks outputs are held.
    initial begin
        exp_t        e;
        logic [11:0] lr, lg, lb;
        logic [10:0] lx, ly;
        bit          pd;
        lr = '0; lg = '0; lb = '0; lx = '0; ly = '0; pd = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                lr = '0; lg = '0; lb = '0; lx = '0; ly = '0; pd = 1'b0;
            end else begin
                if (oDVAL) begin
                    check("no_back_to_back", 64'(pd), 64'(0));
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_odval actual=1 required=0 cyc=%0d x=%0d y=%0d", cyc, oX_CONT, oY_CONT);
                    end else begin
                        e = q.pop_front();
                        n_out++;
                        check("out_cycle", 64'(cyc), 64'(e.at));
                        check("oR", 64'(oR), 64'(e.r));
                        check("oG", 64'(oG), 64'(e.g));
                        check("oB", 64'(oB), 64'(e.b));
                        check("oX_CONT", 64'(oX_CONT), 64'(e.x));
                        check("oY_CONT", 64'(oY_CONT), 64'(e.y));
                        $display("pixel x=%0d y=%0d R=%0d G=%0d B=%0d cyc=%0d", oX_CONT, oY_CONT, oR, oG, oB, cyc);
                    end
                    lr = oR; lg = oG; lb = oB; lx = oX_CONT; ly = oY_CONT;
                end else begin
                    check("hold", {6'd0, oR, oG, oB, oX_CONT, oY_CONT}, {6'd0, lr, lg, lb, lx, ly});
                end
                pd = oDVAL;
            end
        end
    end

    initial begin
        exp_t e;
        int   base;

        repeat (3) @(negedge CLK);
        check("reset_out", {oR, oG, oB, oX_CONT, oY_CONT, oDVAL}, 64'd0);
        check("reset_frame_cnt", 64'(oFRAME_CNT), 64'd0);
        RESET_N = 1'b1;
        idle(2);

        // Uniform 4-row frame: R=200, G=(100+101)>>1=100, B=300.
        base = n_out;
        fill(12'd100, 12'd200); send_line(8, 0); idle(2);
        fill(12'd300, 12'd101); send_line(8, 0); idle(2);
        fill(12'd100, 12'd200); send_line(8, 0); idle(2);
        fill(12'd300, 12'd101); send_line(8, 0); idle(2);
        check("frame_cnt_pre", 64'(oFRAME_CNT), 64'd0);
        frame_end();
        idle(2);
        check("frame1_pulses", 64'(n_out - base), 64'd8);

        // 10-pixel lines, G extremes, then a truncated even row (stale cols 4..7).
        base = n_out;
        line_px[0] = 12'd4095; line_px[1] = 12'd11;  line_px[2] = 12'd0;   line_px[3] = 12'd13;
        line_px[4] = 12'd500;  line_px[5] = 12'd15;  line_px[6] = 12'd777; line_px[7] = 12'd17;
        line_px[8] = 12'd999;  line_px[9] = 12'd998;
        send_line(10, 0); idle(2);
        line_px[0] = 12'd20;   line_px[1] = 12'd4095; line_px[2] = 12'd22;  line_px[3] = 12'd1;
        line_px[4] = 12'd24;   line_px[5] = 12'd600;  line_px[6] = 12'd26;  line_px[7] = 12'd778;
        line_px[8] = 12'd50;   line_px[9] = 12'd51;
        send_line(10, 0); idle(3);
        check("g_max_no_overflow", 64'(oG), 64'd777);
        check("row1_pulses", 64'(n_out - base), 64'd4);
        for (int c = 0; c < 4; c++) line_px[c] = 12'(1000 + c);
        send_line(4, 0); idle(2);
        for (int c = 0; c < 8; c++) line_px[c] = 12'(40 + c);
        send_line(8, 0); idle(3);
        check("frame2_pulses", 64'(n_out - base), 64'd8);
        check("last_r_stale", 64'(oR), 64'd17);
        frame_end();

        // Reset pulsed mid odd row drops the in-flight pixel.
        fill(12'd100, 12'd200); send_line(8, 0); idle(2);
        fill(12'd300, 12'd101);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            iFVAL = 1'b1; iDVAL = 1'b1; iDATA = line_px[c];
            if (c == 1) begin
                e.r = 12'd200; e.g = 12'd100; e.b = 12'd300; e.x = '0; e.y = '0; e.at = cyc + 2;
                q.push_back(e);
            end
        end
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_out", {oR, oG, oB, oX_CONT, oY_CONT, oDVAL}, 64'd0);
        check("async_reset_frame_cnt", 64'(oFRAME_CNT), 64'd0);
        q.delete();
        iDVAL = 1'b0; iFVAL = 1'b0;
        exp_frames = '0; brow = 0;
        @(negedge CLK); @(negedge CLK);
        RESET_N = 1'b1;
        base = n_out;
        send_line(8, 0); idle(3);
        check("post_reset_row0_silent", 64'(n_out - base), 64'd0);
        fill(12'd7, 12'd9); send_line(8, 0); idle(3);
        check("post_reset_pair_pulses", 64'(n_out - base), 64'd4);
        frame_end();

        // Empty frames up to 15, then a frame whose last G2 is followed by iFVAL low.
        while (exp_frames != 4'd15) begin
            @(negedge CLK);
            iFVAL = 1'b1;
            frame_end();
        end
        base = n_out;
        fill(12'd5, 12'd6); send_line(8, 0); idle(1);
        fill(12'd7, 12'd8); send_line(8, 1);
        idle(4);
        check("fval_drop_pulses", 64'(n_out - base), 64'd4);
        check("frame_cnt_wrap", 64'(oFRAME_CNT), 64'd0);

        idle(4);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bayer_to_rgb.md
BAYER_TO_RGB -- requirements
Module: bayer_to_rgb

Interface
REQ-001 Parameter LINE_WIDTH, default 1600: raw Bayer pixels per line; even, range 4..2048.
REQ-002 Parameter FRAME_CNT_W, default 16: width of the frame counter.
REQ-003 CLK  input  1: pixel clock (D5M_PIXLCLK domain); all state changes on its rising edge.
REQ-004 RESET_N  input  1: reset, asynchronous, active-low.
REQ-005 iDATA  input  12: raw Bayer pixel, sampled when iDVAL=1.
REQ-006 iDVAL  input  1: pixel valid; high for a contiguous run of pixels per line.
REQ-007 iFVAL  input  1: frame valid; low between frames.
REQ-008 oR, oG, oB  output  12 each: demosaiced colour components.
REQ-009 oDVAL  output  1: one-cycle strobe per output RGB pixel.
REQ-010 oX_CONT  output  11: output column, 0..LINE_WIDTH/2-1.
REQ-011 oY_CONT  output  11: output row.
REQ-012 oFRAME_CNT  output  FRAME_CNT_W: count of completed frames.

Function
REQ-013 The Bayer layout SHALL be: even rows G1,R,G1,R...; odd rows B,G2,B,G2... (column 0 green on even rows).
REQ-014 Input column counter col SHALL increment on each cycle with iDVAL=1 and SHALL clear on any cycle with iDVAL=0.
REQ-015 Input row counter row SHALL increment on the first cycle with iDVAL=0 after a cycle with iDVAL=1 (line end); a mid-line iDVAL gap SHALL count as a line end.
REQ-016 row SHALL saturate at 2047; col SHALL saturate at 2047.
REQ-017 On even rows, pixels with col < LINE_WIDTH SHALL be written into a LINE_WIDTH x 12 line buffer at address col.
REQ-018 On odd rows, the line buffer SHALL be read at address col with one-cycle registered read latency; B (even col) and buffered G1 SHALL be held until the following odd-col pixel.
REQ-019 On an odd row at odd col c < LINE_WIDTH, the block SHALL form R = buffered R(c), B = held B(c-1), G = (G1 + G2) >> 1 using a 13-bit sum, truncated.
REQ-020 The result SHALL appear with oDVAL=1 exactly 2 cycles after the cycle accepting that odd-col G2 pixel.
REQ-021 In the same cycle, oX_CONT SHALL equal (c-1)/2 and oY_CONT SHALL equal (row-1)/2.
REQ-022 Pixels with col >= LINE_WIDTH SHALL be discarded: no buffer write and no output.
REQ-023 oR/oG/oB/oX_CONT/oY_CONT SHALL hold their last values while oDVAL=0.
REQ-024 A cycle with iFVAL=0 SHALL clear row and col; iDATA/iDVAL SHALL be ignored while iFVAL=0.
REQ-025 Results already in the 2-stage pipeline SHALL still be emitted after iFVAL falls.
REQ-026 oFRAME_CNT SHALL increment on each iFVAL 1->0 transition and wrap modulo 2^FRAME_CNT_W.
REQ-027 An odd row whose preceding even row was truncated SHALL use stale buffer contents for columns not rewritten; no error is flagged.
REQ-028 oDVAL SHALL never be asserted on two consecutive cycles.

Reset
REQ-029 RESET_N=0 SHALL immediately force oR, oG, oB, oX_CONT, oY_CONT, oFRAME_CNT to 0, oDVAL to 0, and clear row, col, pipeline and held registers.
REQ-030 Line buffer contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted mid-line SHALL drop in-flight pixels; after release, the first pixel is treated as row 0, col 0 once iFVAL=1.

Verification (LINE_WIDTH=8)
REQ-032 One 4-row frame with G1=100, R=200, B=300, G2=101 at every site -> 8 oDVAL pulses with R=200, G=100, B=300, oX_CONT 0..3, oY_CONT 0 then 1; oFRAME_CNT 0->1.
REQ-033 Odd row G2 accepted at cycle T (col 1) -> oDVAL=1 at T+2 only, with oX_CONT=0.
REQ-034 Line of 10 pixels -> cols 8,9 produce no output and do not corrupt buffer entry 0; exactly 4 outputs per odd row.
REQ-035 G1=4095, G2=4095 -> oG=4095 (no overflow); G1=0, G2=1 -> oG=0.
REQ-036 RESET_N pulsed low mid odd-row -> all outputs 0 asynchronously; no oDVAL until a new even/odd row pair is received.
REQ-037 iFVAL dropped 1 cycle after a final G2 -> that pixel still emitted at T+2; oFRAME_CNT wraps 0xFFFF->0x0000 on the next frame end.
